// File: rtl/if_stage_if.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | if_stage_if : control/loader/IF-ID bundle of the fetch stage          |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface if_stage_if #(
  parameter int N_BITS    = 32,
  parameter int ADDR_BITS = 8
);
  logic                 i_enable;
  logic                 i_stall;
  logic                 i_jump_taken;
  logic [N_BITS-1:0]    i_pc_jump;
  logic                 i_branch_taken;
  logic [N_BITS-1:0]    i_pc_branch;
  logic                 i_imem_wr_en;
  logic [ADDR_BITS-1:0] i_imem_wr_addr;
  logic [N_BITS-1:0]    i_imem_wr_data;
  logic [N_BITS-1:0]    o_pc;
  logic [N_BITS-1:0]    o_instr;
  logic [N_BITS-1:0]    o_pc_4;
  logic                 o_valid;
  logic                 o_halt;

  modport master (
    output i_enable, i_stall, i_jump_taken, i_pc_jump, i_branch_taken,
           i_pc_branch, i_imem_wr_en, i_imem_wr_addr, i_imem_wr_data,
    input  o_pc, o_instr, o_pc_4, o_valid, o_halt
  );

  modport slave (
    input  i_enable, i_stall, i_jump_taken, i_pc_jump, i_branch_taken,
           i_pc_branch, i_imem_wr_en, i_imem_wr_addr, i_imem_wr_data,
    output o_pc, o_instr, o_pc_4, o_valid, o_halt
  );
endinterface
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | if_stage : MIPS instruction fetch - PC, instruction memory, IF/ID reg |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module if_stage #(
  parameter int                N_BITS     = 32,
  parameter int                IMEM_DEPTH = 256,
  parameter logic [N_BITS-1:0] HALT_CODE  = 32'hFFFF_FFFF
) (
  input  wire logic  i_clock,
  input  wire logic  i_reset,
  if_stage_if.slave  bus
);

  localparam int c_addr_bits = $clog2(IMEM_DEPTH);
  localparam logic [N_BITS-1:0] c_pc_step = N_BITS'(4);

  logic [N_BITS-1:0] r_mem [IMEM_DEPTH];

  logic [N_BITS-1:0] r_pc;
  logic [N_BITS-1:0] r_instr;
  logic [N_BITS-1:0] r_pc_4;
  logic              r_valid;
  logic              r_halt;

  logic [c_addr_bits-1:0] w_rd_idx;
  logic [N_BITS-1:0]      w_fetch;
  logic [N_BITS-1:0]      w_pc_plus4;
  logic                   w_redirect;
  logic [N_BITS-1:0]      w_redirect_pc;

  // Loader writes bypass every run-control input, so the debug unit can patch code while frozen.
  always_ff @(posedge i_clock) begin
    if (bus.i_imem_wr_en) begin
      r_mem[bus.i_imem_wr_addr] <= bus.i_imem_wr_data;
    end
  end

  assign w_rd_idx      = r_pc[c_addr_bits+1:2];
  assign w_fetch       = r_mem[w_rd_idx];
  assign w_pc_plus4    = r_pc + c_pc_step;
  assign w_redirect    = bus.i_branch_taken | bus.i_jump_taken;
  assign w_redirect_pc = bus.i_branch_taken ? bus.i_pc_branch : bus.i_pc_jump;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_pc    <= '0;
      r_instr <= '0;
      r_pc_4  <= '0;
      r_valid <= 1'b0;
      r_halt  <= 1'b0;
    end else if (bus.i_enable && !bus.i_stall) begin
      if (w_redirect) begin
        r_pc    <= w_redirect_pc;
        r_instr <= '0;
        r_valid <= 1'b0;
      end else if (r_halt) begin
        r_instr <= '0;
        r_valid <= 1'b0;
      end else begin
        r_instr <= w_fetch;
        r_pc_4  <= w_pc_plus4;
        r_valid <= 1'b1;
        // A fetched HALT parks the PC on itself; only a redirect or reset moves it again.
        if (w_fetch == HALT_CODE) begin
          r_halt <= 1'b1;
        end else begin
          r_pc   <= w_pc_plus4;
        end
      end
    end
  end

  assign bus.o_pc    = r_pc;
  assign bus.o_instr = r_instr;
  assign bus.o_pc_4  = r_pc_4;
  assign bus.o_valid = r_valid;
  assign bus.o_halt  = r_halt;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_if_stage : directed + random fetch-stage bench with a word model   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_if_stage;

  localparam int          N_BITS = 32;
  localparam int          DEPTH  = 256;
  localparam int          AW     = 8;
  localparam logic [31:0] HALT   = 32'hFFFF_FFFF;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  if_stage_if #(.N_BITS(N_BITS), .ADDR_BITS(AW)) bus();

  if_stage #(.N_BITS(N_BITS), .IMEM_DEPTH(DEPTH), .HALT_CODE(HALT)) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  // reference state: memory as a word array, the PC as a byte address
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_halt;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check_val("pc",    bus.o_pc,            m_pc);
    check_val("instr", bus.o_instr,         m_instr);
    check_val("valid", 32'(bus.o_valid),    32'(m_valid));
    check_val("halt",  32'(bus.o_halt),     32'(m_halt));
    if (m_valid) check_val("pc_4", bus.o_pc_4, m_pc4);
  endtask

  task automatic model_reset();
    m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_halt = 0;
  endtask

  // one clock edge of the fetch stage, written from the priority rules
  task automatic model_edge();
    logic [31:0] word;
    word = m_mem[(m_pc >> 2) % DEPTH];
    if (bus.i_imem_wr_en) m_mem[bus.i_imem_wr_addr] = bus.i_imem_wr_data;
    if (!bus.i_enable || bus.i_stall) return;
    if (bus.i_branch_taken || bus.i_jump_taken) begin
      m_pc    = bus.i_branch_taken ? bus.i_pc_branch : bus.i_pc_jump;
      m_instr = 0;
      m_valid = 0;
    end else if (m_halt) begin
      m_instr = 0;
      m_valid = 0;
    end else begin
      m_instr = word;
      m_valid = 1;
      m_pc4   = m_pc + 4;
      if (word == HALT) m_halt = 1;
      else              m_pc   = m_pc + 4;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle_inputs(input logic en);
    bus.i_enable       = en;
    bus.i_stall        = 0;
    bus.i_jump_taken   = 0;
    bus.i_pc_jump      = 0;
    bus.i_branch_taken = 0;
    bus.i_pc_branch    = 0;
    bus.i_imem_wr_en   = 0;
    bus.i_imem_wr_addr = 0;
    bus.i_imem_wr_data = 0;
  endtask

  task automatic load(input int addr, input logic [31:0] data);
    idle_inputs(1'b0);
    bus.i_imem_wr_en   = 1;
    bus.i_imem_wr_addr = AW'(addr);
    bus.i_imem_wr_data = data;
    tick();
    bus.i_imem_wr_en   = 0;
  endtask

  // called between edges: outputs must clear without any clock edge
  task automatic do_reset();
    rst_n = 0;
    #1;
    model_reset();
    check_val("rst_pc",    bus.o_pc,         32'h0);
    check_val("rst_instr", bus.o_instr,      32'h0);
    check_val("rst_pc4",   bus.o_pc_4,       32'h0);
    check_val("rst_valid", 32'(bus.o_valid), 32'h0);
    check_val("rst_halt",  32'(bus.o_halt),  32'h0);
    #1;
    rst_n = 1;
  endtask

  initial begin
    logic [31:0] w;
    idle_inputs(1'b0);
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
    model_reset();
    #2;
    do_reset();

    // fill memory: A..D at 0..3, a marker at 16, random elsewhere
    for (int i = 0; i < DEPTH; i++) begin
      if (i < 4)        w = 32'h1111_0000 + 32'(i);
      else if (i == 16) w = 32'h2222_0016;
      else begin
        w = $urandom;
        if (w == HALT) w = 32'h0;
      end
      load(i, w);
    end

    // sequential fetch
    idle_inputs(1'b1);
    tick();
    check_val("seq_pc4",   bus.o_pc,    32'h4);
    check_val("seq_instrA", bus.o_instr, 32'h1111_0000);
    tick();
    check_val("seq_pc8",   bus.o_pc,    32'h8);

    // jump at PC=8 to 0x40, one bubble then word 16
    bus.i_jump_taken = 1; bus.i_pc_jump = 32'h40;
    tick();
    check_val("jmp_pc", bus.o_pc, 32'h40);
    bus.i_jump_taken = 0;
    tick();
    check_val("jmp_instr", bus.o_instr, 32'h2222_0016);
    check_val("jmp_pc4",   bus.o_pc_4,  32'h44);

    // branch beats jump, then a stall masks a redirect
    bus.i_branch_taken = 1; bus.i_pc_branch = 32'h20;
    bus.i_jump_taken   = 1; bus.i_pc_jump   = 32'h40;
    tick();
    check_val("brj_pc", bus.o_pc, 32'h20);
    bus.i_jump_taken = 0; bus.i_pc_branch = 32'h80; bus.i_stall = 1;
    tick();
    tick();
    check_val("stall_pc", bus.o_pc, 32'h20);
    idle_inputs(1'b1);

    // frozen while the loader writes word 5
    for (int i = 0; i < 3; i++) begin
      bus.i_enable = 0; bus.i_imem_wr_en = 1;
      bus.i_imem_wr_addr = AW'(5); bus.i_imem_wr_data = 32'h5555_0000 + 32'(i);
      tick();
    end
    idle_inputs(1'b1);

    // PC wrap: 0xFFFFFFFC fetches word 255, then word 0
    bus.i_jump_taken = 1; bus.i_pc_jump = 32'hFFFF_FFFC;
    tick();
    bus.i_jump_taken = 0;
    tick();
    check_val("wrap_pc", bus.o_pc, 32'h0);
    tick();
    check_val("wrap_instr0", bus.o_instr, 32'h1111_0000);

    // run to 0x24 and reset mid-run
    for (int i = 0; i < 16 && m_pc != 32'h24; i++) tick();
    check_val("pre_rst_pc", bus.o_pc, 32'h24);
    do_reset();
    tick();
    check_val("restart_instr", bus.o_instr, 32'h1111_0000);

    // HALT at word 2
    load(2, HALT);
    idle_inputs(1'b1);
    tick();
    tick();
    check_val("halt_flag",  32'(bus.o_halt), 32'h1);
    check_val("halt_pc",    bus.o_pc,        32'h8);
    check_val("halt_instr", bus.o_instr,     HALT);
    tick();
    tick();
    check_val("halt_bubble", 32'(bus.o_valid), 32'h0);
    bus.i_jump_taken = 1; bus.i_pc_jump = 32'h40;
    tick();
    check_val("halt_jmp_pc", bus.o_pc, 32'h40);
    bus.i_jump_taken = 0;
    tick();
    check_val("halt_sticky", 32'(bus.o_halt), 32'h1);

    // random phase
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom % 150 == 0) do_reset();
      bus.i_enable       = ($urandom % 8) != 0;
      bus.i_stall        = ($urandom % 6) == 0;
      bus.i_branch_taken = ($urandom % 10) == 0;
      bus.i_pc_branch    = $urandom & 32'h3FF;
      bus.i_jump_taken   = ($urandom % 8) == 0;
      bus.i_pc_jump      = ($urandom % 16 == 0) ? 32'hFFFF_FFF0 | ($urandom & 32'hF)
                                                : ($urandom & 32'h3FF);
      bus.i_imem_wr_en   = ($urandom % 4) == 0;
      bus.i_imem_wr_addr = AW'($urandom);
      bus.i_imem_wr_data = ($urandom % 6 == 0) ? HALT : $urandom;
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
